// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared definitions for the SPI transfer sequencer: state encoding, default field widths
// and the edge-select helper used for the TX/RX strobes.
package spi_xfer_ctrl_pkg;

  localparam int SPI_CHAR_LEN_BITS = 7;
  localparam int SPI_SS_NB         = 8;
  localparam int SPI_DLY_W         = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic edge_sel(input logic use_neg, input logic pos_e, input logic neg_e);
    return use_neg ? neg_e : pos_e;
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Command, configuration, clock-generator and status signals of the transfer sequencer.
// The master side issues start/abort and edge pulses; no flow control, all single-cycle pulses.
interface spi_xfer_ctrl_if
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int CHAR_LEN_W = SPI_CHAR_LEN_BITS,
  parameter int SS_NB      = SPI_SS_NB,
  parameter int DLY_W      = SPI_DLY_W
);
  logic                  start_i;
  logic                  abort_i;
  logic [CHAR_LEN_W-1:0] char_len_i;
  logic [SS_NB-1:0]      ss_i;
  logic                  ass_i;
  logic                  tx_neg_i;
  logic                  rx_neg_i;
  logic [DLY_W-1:0]      lead_i;
  logic [DLY_W-1:0]      trail_i;
  logic                  pos_edge_i;
  logic                  neg_edge_i;
  logic                  clk_en_o;
  logic                  go_o;
  logic                  last_clk_o;
  logic                  tx_shift_o;
  logic                  rx_sample_o;
  logic [CHAR_LEN_W:0]   bit_cnt_o;
  logic [SS_NB-1:0]      ss_n_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    output start_i, abort_i, char_len_i, ss_i, ass_i, tx_neg_i, rx_neg_i, lead_i, trail_i,
           pos_edge_i, neg_edge_i,
    input  clk_en_o, go_o, last_clk_o, tx_shift_o, rx_sample_o, bit_cnt_o, ss_n_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, char_len_i, ss_i, ass_i, tx_neg_i, rx_neg_i, lead_i, trail_i,
           pos_edge_i, neg_edge_i,
    output clk_en_o, go_o, last_clk_o, tx_shift_o, rx_sample_o, bit_cnt_o, ss_n_o, busy_o, done_o
  );

endinterface

// File: rtl/spi_cs_delay.sv
// Loadable saturating down-counter with zero flag, timing chip-select setup and hold.
// Load takes effect next cycle and wins over decrement; no backpressure.
module spi_cs_delay #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: start/abort FSM, CS setup/hold, bit counting and shift/sample strobes.
// Busy one cycle after start; strobes combinational with edge pulses; start ignored while busy.
module spi_xfer_ctrl
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int CHAR_LEN_W = SPI_CHAR_LEN_BITS,
  parameter int SS_NB      = SPI_SS_NB,
  parameter int DLY_W      = SPI_DLY_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  spi_xfer_ctrl_if.slave  bus
);

  localparam int CNT_W = CHAR_LEN_W + 1;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [SS_NB-1:0]   ss_l;
  logic               ass_l;
  logic               tx_neg_l;
  logic               rx_neg_l;
  logic [DLY_W-1:0]   trail_l;
  logic               go;
  logic               done;
  logic               busy;
  logic               clk_en;

  logic               in_xfer;
  logic               tx_edge;
  logic               rx_edge;
  logic               accept;
  logic               last_rx;
  logic               dly_load;
  logic [DLY_W-1:0]   dly_val;
  logic               dly_dec;
  logic               dly_zero;
  logic [SS_NB-1:0]   ss_n;

  assign in_xfer = (state == ST_XFER);
  assign tx_edge = edge_sel(tx_neg_l, bus.pos_edge_i, bus.neg_edge_i);
  assign rx_edge = edge_sel(rx_neg_l, bus.pos_edge_i, bus.neg_edge_i);
  assign accept  = (state == ST_IDLE) && bus.start_i && !bus.abort_i;
  assign last_rx = in_xfer && rx_edge && (bit_cnt == CNT_W'(1));

  // One counter serves both delays: lead is loaded on start, trail on the final sample.
  always_comb begin
    dly_load = accept || last_rx;
    dly_val  = accept ? bus.lead_i : trail_l;
    dly_dec  = (state == ST_SETUP) || (state == ST_HOLD);
  end

  spi_cs_delay #(.W(DLY_W)) u_cs_delay (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load     (dly_load),
    .load_val (dly_val),
    .dec      (dly_dec),
    .zero     (dly_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      ss_l     <= '0;
      ass_l    <= 1'b0;
      tx_neg_l <= 1'b0;
      rx_neg_l <= 1'b0;
      trail_l  <= '0;
      go       <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      clk_en   <= 1'b0;
    end else begin
      go   <= 1'b0;
      done <= 1'b0;
      if (bus.abort_i) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        clk_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start_i) begin
              ss_l     <= bus.ss_i;
              ass_l    <= bus.ass_i;
              tx_neg_l <= bus.tx_neg_i;
              rx_neg_l <= bus.rx_neg_i;
              trail_l  <= bus.trail_i;
              bit_cnt  <= (bus.char_len_i == '0) ? {1'b1, {CHAR_LEN_W{1'b0}}}
                                                 : {1'b0, bus.char_len_i};
              busy     <= 1'b1;
              if (bus.ass_i) begin
                state <= ST_SETUP;
              end else begin
                state  <= ST_XFER;
                go     <= 1'b1;
                clk_en <= 1'b1;
              end
            end
          end
          ST_SETUP: begin
            if (dly_zero) begin
              state  <= ST_XFER;
              go     <= 1'b1;
              clk_en <= 1'b1;
            end
          end
          ST_XFER: begin
            if (rx_edge) begin
              if (bit_cnt != '0) bit_cnt <= bit_cnt - CNT_W'(1);
              if (bit_cnt == CNT_W'(1)) begin
                clk_en <= 1'b0;
                if (ass_l) begin
                  state <= ST_HOLD;
                end else begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end
              end
            end
          end
          ST_HOLD: begin
            if (dly_zero) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Manual select follows the live mask; automatic select drives only SETUP through HOLD.
  always_comb begin
    ss_n = '1;
    if (state == ST_IDLE) begin
      ss_n = bus.ass_i ? '1 : ~bus.ss_i;
    end else if (!ass_l) begin
      ss_n = ~bus.ss_i;
    end else if (state == ST_SETUP || state == ST_XFER || state == ST_HOLD) begin
      ss_n = ~ss_l;
    end
  end

  assign bus.clk_en_o    = clk_en;
  assign bus.go_o        = go;
  assign bus.last_clk_o  = in_xfer && (bit_cnt == CNT_W'(1));
  assign bus.tx_shift_o  = in_xfer && tx_edge && (bit_cnt != '0);
  assign bus.rx_sample_o = in_xfer && rx_edge;
  assign bus.bit_cnt_o   = bit_cnt;
  assign bus.ss_n_o      = ss_n;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl: stimulus queues per-transfer expectations, a monitor
// pops them when a transfer begins and checks strobe counts and timing at completion/abort.
module tb_spi_xfer_ctrl;
  import spi_xfer_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_xfer_ctrl_if bus ();

  spi_xfer_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int         n;
    logic [7:0] ss;
    bit         ass;
    bit         tx_neg;
    bit         rx_neg;
    int         lead;
    int         trail;
    int         div;
    int         abort_after;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stray  = 0;
  int   div_sel = 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference rules for the generator model below: edges alternate pos/neg starting with pos,
  // one every div+1 enabled cycles; divider 0 gives both edges every cycle.
  function automatic int exp_tx(input exp_t e);
    if (e.div != 0 && e.tx_neg && !e.rx_neg) return e.n - 1;
    return e.n;
  endfunction

  function automatic int exp_xfer_cycles(input exp_t e);
    if (e.div == 0) return e.n;
    return (2 * e.n - (e.rx_neg ? 0 : 1)) * (e.div + 1);
  endfunction

  // Clock generator model
  initial begin
    int c;
    bit lvl;
    c = 0;
    lvl = 1'b0;
    bus.pos_edge_i = 1'b0;
    bus.neg_edge_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.pos_edge_i = 1'b0;
      bus.neg_edge_i = 1'b0;
      if (!bus.clk_en_o) begin
        c = 0;
        lvl = 1'b0;
      end else if (div_sel == 0) begin
        bus.pos_edge_i = 1'b1;
        bus.neg_edge_i = 1'b1;
      end else if (c == div_sel) begin
        c = 0;
        if (!lvl) bus.pos_edge_i = 1'b1;
        else      bus.neg_edge_i = 1'b1;
        lvl = ~lvl;
      end else begin
        c++;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    logic [7:0] act_n;
    bit active, busy_prev, done_seen, go_seen;
    int cyc, samples, tx, gos, xfer_cyc, setup_cyc, hold_cyc, last_cyc, done_cyc, lc_err, ss_err;
    active = 0; busy_prev = 0; done_seen = 0; go_seen = 0; cyc = 0;
    samples = 0; tx = 0; gos = 0; xfer_cyc = 0; setup_cyc = 0; hold_cyc = 0;
    last_cyc = 0; done_cyc = 0; lc_err = 0; ss_err = 0; act_n = '1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (bus.busy_o && !busy_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_start", 1, 0);
            active = 0;
          end else begin
            e = exp_q.pop_front();
            act_n = ~e.ss;
            active = 1; done_seen = 0; go_seen = 0;
            samples = 0; tx = 0; gos = 0; xfer_cyc = 0; setup_cyc = 0; hold_cyc = 0;
            lc_err = 0; ss_err = 0; last_cyc = cyc;
            check("bit_cnt_load", bus.bit_cnt_o, e.n);
          end
        end
        if (active && !bus.busy_o) begin
          if (done_seen) begin
            check("idle_after_done", cyc - done_cyc, 1);
          end else begin
            check("abort_expected", (e.abort_after >= 0) ? 1 : 0, 1);
            check("abort_samples", samples, e.abort_after);
            check("abort_clk_en", bus.clk_en_o, 0);
            check("abort_ss_n", bus.ss_n_o, 8'hFF);
            check("abort_bit_cnt", bus.bit_cnt_o, e.n - e.abort_after);
          end
          active = 0;
        end else if (active) begin
          if (!go_seen && !bus.clk_en_o && bus.ss_n_o == act_n) setup_cyc++;
          if (bus.go_o) begin
            gos++;
            if (!go_seen) begin
              check("go_with_clk_en", bus.clk_en_o, 1);
              check("setup_cycles", setup_cyc, e.ass ? e.lead + 1 : 0);
            end
            go_seen = 1;
          end
          if (bus.clk_en_o) begin
            xfer_cyc++;
            if (bus.ss_n_o != act_n) ss_err++;
          end
          if (bus.last_clk_o != (bus.clk_en_o && samples == e.n - 1)) lc_err++;
          if (bus.rx_sample_o) begin
            check("bit_cnt_at_sample", bus.bit_cnt_o, e.n - samples);
            samples++;
            last_cyc = cyc;
          end
          if (bus.tx_shift_o) tx++;
          if (samples == e.n && !bus.clk_en_o && !bus.done_o && bus.ss_n_o == act_n) hold_cyc++;
          if (bus.done_o) begin
            check("done_expected", (e.abort_after < 0) ? 1 : 0, 1);
            check("rx_samples", samples, e.n);
            check("tx_shifts", tx, exp_tx(e));
            check("go_pulses", gos, 1);
            check("xfer_cycles", xfer_cyc, exp_xfer_cycles(e));
            check("last_clk_errs", lc_err, 0);
            check("ss_n_xfer_errs", ss_err, 0);
            check("hold_cycles", hold_cyc, e.ass ? e.trail + 1 : 0);
            check("done_latency", cyc - last_cyc, e.ass ? e.trail + 2 : 1);
            check("ss_n_done", bus.ss_n_o, e.ass ? 8'hFF : act_n);
            check("bit_cnt_final", bus.bit_cnt_o, 0);
            done_seen = 1;
            done_cyc = cyc;
          end
        end else if (bus.rx_sample_o || bus.tx_shift_o || bus.go_o || bus.done_o || bus.clk_en_o) begin
          stray++;
        end
      end
      busy_prev = bus.busy_o;
    end
  end

  task automatic run_xfer(input int len_field, input logic [7:0] ss, input bit ass,
                          input bit txn, input bit rxn, input int lead, input int trail,
                          input int div, input int abort_after, input bit mid_start);
    exp_t e;
    int budget;
    int seen;
    e.n = (len_field == 0) ? 128 : len_field;
    e.ss = ss; e.ass = ass; e.tx_neg = txn; e.rx_neg = rxn;
    e.lead = lead; e.trail = trail; e.div = div; e.abort_after = abort_after;
    exp_q.push_back(e);
    div_sel = div;
    bus.char_len_i = 7'(len_field);
    bus.ss_i = ss;
    bus.ass_i = ass;
    bus.tx_neg_i = txn;
    bus.rx_neg_i = rxn;
    bus.lead_i = 4'(lead);
    bus.trail_i = 4'(trail);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("busy_after_start", bus.busy_o, 1);
    if (mid_start) begin
      budget = 200;
      while (!bus.clk_en_o && budget > 0) begin @(negedge clk); budget--; end
      @(posedge clk); #1;
      bus.char_len_i = 7'd3;
      bus.ss_i = 8'h01;
      bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
    end
    if (abort_after >= 0) begin
      seen = 0;
      budget = 2000;
      while (seen < abort_after && budget > 0) begin
        @(negedge clk);
        if (bus.rx_sample_o) seen++;
        budget--;
      end
      @(posedge clk); #1;
      bus.abort_i = 1'b1;
      @(posedge clk); #1;
      bus.abort_i = 1'b0;
    end
    budget = 4000;
    while (bus.busy_o && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) begin
      check("xfer_timeout", 1, 0);
      @(posedge clk); #1;
      bus.abort_i = 1'b1;
      @(posedge clk); #1;
      bus.abort_i = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.char_len_i = '0;
    bus.ss_i = '0;
    bus.ass_i = 1'b0;
    bus.tx_neg_i = 1'b0;
    bus.rx_neg_i = 1'b0;
    bus.lead_i = '0;
    bus.trail_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ss_n", bus.ss_n_o, 8'hFF);
    check("rst_bit_cnt", bus.bit_cnt_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_clk_en", bus.clk_en_o, 0);
    check("rst_go", bus.go_o, 0);
    check("rst_last_clk", bus.last_clk_o, 0);
    check("rst_rx_sample", bus.rx_sample_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_xfer(8, 8'h01, 0, 0, 0, 0, 0, 1, -1, 0);   // basic 8-bit
    run_xfer(8, 8'h04, 1, 0, 0, 3, 2, 1, -1, 0);   // auto select with delays
    run_xfer(0, 8'h80, 0, 0, 1, 0, 0, 0, -1, 0);   // maximum length
    run_xfer(4, 8'h02, 0, 1, 0, 0, 0, 0, -1, 0);   // divider 0
    run_xfer(8, 8'h08, 1, 0, 0, 1, 1, 1, 3, 0);    // abort after 3 samples

    bus.ass_i = 1'b1;
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    @(negedge clk);
    check("abort_start_idle_busy", bus.busy_o, 0);
    check("abort_start_idle_ss_n", bus.ss_n_o, 8'hFF);
    repeat (2) @(posedge clk);
    #1;

    run_xfer(8, 8'h10, 1, 0, 0, 0, 0, 1, -1, 1);   // start while busy
    run_xfer(1, 8'h20, 1, 1, 1, 2, 0, 2, -1, 0);   // single bit

    for (int i = 0; i < 12; i++) begin
      run_xfer(int'($urandom_range(1, 20)), 8'($urandom_range(1, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)), -1, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    check("stray_outputs", stray, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
